gpio_cfg_loader: RTL and testbench
==================================

// Module: gpio_cfg_loader
// PURPOSE
//  Sequencer for the GPIO pad-control serial chain (NUM_PADS gpio_control_block instances).
//  Holds one CTRL_BITS config word per pad in a local register file written by the SoC,
//  then shifts the whole image into the chain and pulses serial_load to apply it.
//  Sits between the SoC register bus and the gpio_right/gpio_left serial_* inputs.
// PARAMETERS
//  NUM_PADS     15      pads in the chain
//  CTRL_BITS    12      config bits per pad
//  CLK_DIV      4       mclk cycles per serial_clock half-period (>=1)
//  DEFAULT_CFG  12'hC00 reset value of every config word
//  AUTO_LOAD    1       1 = run one load automatically after reset release
// PORTS
//  mclk           in   1                  system clock
//  reset          in   1                  async active-high reset
//  cfg_we         in   1                  config word write strobe
//  cfg_addr       in   $clog2(NUM_PADS)   pad index for write/read
//  cfg_wdata      in   CTRL_BITS          config word to write
//  cfg_rdata      out  CTRL_BITS          word at cfg_addr (combinational read)
//  start          in   1                  1-cycle request to load chain
//  busy           out  1                  load sequence in progress
//  done           out  1                  1-cycle pulse: load complete
//  cfg_wr_err     out  1                  1-cycle pulse: write rejected
//  serial_resetn  out  1                  chain reset, low while reset
//  serial_clock   out  1                  chain shift clock
//  serial_data    out  1                  chain shift data
//  serial_load    out  1                  chain load strobe
// BEHAVIOUR
//  Reset: all regs = DEFAULT_CFG; state IDLE; busy/done/cfg_wr_err/serial_clock/serial_data/
//   serial_load = 0; serial_resetn = 0 asynchronously, goes 1 on first mclk after reset release.
//  FSM: IDLE -> SHIFT_LO -> SHIFT_HI -> (SHIFT_LO | LOAD_SETUP) -> LOAD -> DONE -> IDLE.
//   IDLE: start=1 (or first cycle after reset release if AUTO_LOAD) -> SHIFT_LO next cycle.
//   SHIFT_LO: CLK_DIV cycles, serial_clock=0, serial_data = current bit (changes on entry only).
//   SHIFT_HI: CLK_DIV cycles, serial_clock=1, data held; last bit -> LOAD_SETUP else SHIFT_LO.
//   LOAD_SETUP: CLK_DIV cycles, clock=0. LOAD: CLK_DIV cycles, serial_load=1. DONE: 1 cycle, done=1.
//  busy = 1 in every state except IDLE (from cycle after start through DONE inclusive).
//  Bit order: NB = NUM_PADS*CTRL_BITS bits; pad NUM_PADS-1 first, each word MSB first;
//   last bit sent is pad 0 bit 0. Counters: pad_idx down NUM_PADS-1..0, bit_idx CTRL_BITS-1..0.
//  Total busy cycles = (2*NB+2)*CLK_DIV + 1 (default: 1449).
//  Writes: cfg_we in IDLE with cfg_addr < NUM_PADS -> word updated next edge.
//   cfg_we while busy, or cfg_addr >= NUM_PADS -> ignored, cfg_wr_err=1 next cycle.
//  Read: cfg_rdata = reg[cfg_addr]; 0 when cfg_addr >= NUM_PADS.
//  start while busy: ignored (no queueing). start and cfg_we same IDLE cycle: write lands,
//   shift uses the new word.
//  reset mid-sequence: immediate return to reset values; chain contents undefined until next load.
// STRUCTURE
//  gpio_cfg_pkg: state enum (IDLE,SHIFT_LO,SHIFT_HI,LOAD_SETUP,LOAD,DONE), CTRL_BITS,
//   DEFAULT_CFG constants shared with gpio_left/gpio_right instantiations.
//  Sub-module gpio_cfg_regfile: NUM_PADS x CTRL_BITS array, write port + async read + bit-select
//   read port (pad_idx, bit_idx) for the shifter. FSM, phase counter, bit/pad counters top-level.
// TESTING
//  Reset, AUTO_LOAD=1: chain model (15 x 12-bit shift regs) holds 12'hC00 in every pad after done.
//  Write pad0=12'h001, pad14=12'h800, start -> chain pad0=001, pad14=800, others C00; busy 1449 cyc.
//  Timing: CLK_DIV=1, single pad -> serial_clock period 2 mclk, data stable across each rise,
//   serial_load high exactly 1 cycle, done one cycle after load falls.
//  cfg_we during busy and cfg_addr=15 in IDLE -> cfg_wr_err pulses, regs unchanged, readback 0 @15.
//  start during busy -> no restart, single done pulse; start+cfg_we same cycle -> new word loaded.
//  Assert reset at bit 90 of shift -> all outputs 0 same cycle; after release clean full reload.

Source files
------------

// File: rtl/gpio_cfg_pkg.sv
// Shared constants and state encoding for the GPIO pad-control chain loader.
package gpio_cfg_pkg;

    localparam int GPIO_CTRL_BITS = 12;
    localparam logic [GPIO_CTRL_BITS-1:0] GPIO_DEFAULT_CFG = 12'hC00;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LOAD_SETUP,
        LOAD,
        DONE
    } state_t;

    // Index width that stays legal when a dimension collapses to one entry.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpio_cfg_regfile.sv
// Per-pad config word storage: one write port, a word read port for the bus and
// a single-bit read port for the serial shifter.
module gpio_cfg_regfile
    import gpio_cfg_pkg::*;
#(
    parameter int NUM_PADS = 15,
    parameter int CTRL_BITS = GPIO_CTRL_BITS,
    parameter logic [CTRL_BITS-1:0] DEFAULT_CFG = GPIO_DEFAULT_CFG,
    localparam int AW = idx_width(NUM_PADS),
    localparam int BW = idx_width(CTRL_BITS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 we_i,
    input  logic [AW-1:0]        waddr_i,
    input  logic [CTRL_BITS-1:0] wdata_i,
    input  logic [AW-1:0]        raddr_i,
    output logic [CTRL_BITS-1:0] rdata_o,
    input  logic [AW-1:0]        bit_pad_i,
    input  logic [BW-1:0]        bit_sel_i,
    output logic                 bit_o
);

    // Sized to the full address space so every index is in range; entries past
    // NUM_PADS are never written and are masked on the bus read.
    localparam int DEPTH = 2**AW;

    logic [CTRL_BITS-1:0] mem_q [DEPTH];

    // NOTE: the array is reset because every word must come up as DEFAULT_CFG;
    // that forces flops rather than a RAM macro, which is fine at this size.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= DEFAULT_CFG;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = (int'(raddr_i) < NUM_PADS) ? mem_q[raddr_i] : '0;
    assign bit_o   = mem_q[bit_pad_i][bit_sel_i];

endmodule

// File: rtl/gpio_cfg_loader.sv
// Sequencer that shifts the per-pad config image into the GPIO serial chain and
// strobes serial_load to apply it.
module gpio_cfg_loader
    import gpio_cfg_pkg::*;
#(
    parameter int NUM_PADS = 15,
    parameter int CTRL_BITS = GPIO_CTRL_BITS,
    parameter int CLK_DIV = 4,
    parameter logic [CTRL_BITS-1:0] DEFAULT_CFG = GPIO_DEFAULT_CFG,
    parameter bit AUTO_LOAD = 1'b1,
    localparam int AW = idx_width(NUM_PADS)
) (
    input  logic                 mclk,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic [AW-1:0]        cfg_addr,
    input  logic [CTRL_BITS-1:0] cfg_wdata,
    output logic [CTRL_BITS-1:0] cfg_rdata,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_wr_err,
    output logic                 serial_resetn,
    output logic                 serial_clock,
    output logic                 serial_data,
    output logic                 serial_load
);

    localparam int BW = idx_width(CTRL_BITS);
    localparam int PW = idx_width(CLK_DIV);
    localparam logic [AW-1:0] LAST_PAD = AW'(NUM_PADS - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(CTRL_BITS - 1);
    localparam logic [PW-1:0] LAST_PH  = PW'(CLK_DIV - 1);

    state_t        state_q;
    logic [PW-1:0] phase_q;
    logic [AW-1:0] pad_q, pad_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          auto_q, busy_q, done_q, wr_err_q;
    logic          sresetn_q, sclk_q, sdata_q, sload_q;
    logic          wr_en, phase_end, last_bit, go, rf_bit, data_d;

    assign wr_en     = cfg_we && (int'(cfg_addr) < NUM_PADS) && (state_q == IDLE);
    assign phase_end = (phase_q == LAST_PH);
    assign last_bit  = (pad_q == '0) && (bit_q == '0);
    assign go        = start || auto_q;

    // Index of the bit to present on the next SHIFT_LO entry.
    // NOTE: every output of an always_comb gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        pad_d = pad_q;
        bit_d = bit_q;
        if (state_q == IDLE) begin
            pad_d = LAST_PAD;
            bit_d = LAST_BIT;
        end else if (!last_bit) begin
            if (bit_q == '0) begin
                pad_d = pad_q - AW'(1);
                bit_d = LAST_BIT;
            end else begin
                bit_d = bit_q - BW'(1);
            end
        end
    end

    // A write landing on the same edge as start must already be seen by the shifter.
    assign data_d = (wr_en && (cfg_addr == pad_d)) ? cfg_wdata[bit_d] : rf_bit;

    gpio_cfg_regfile #(
        .NUM_PADS    (NUM_PADS),
        .CTRL_BITS   (CTRL_BITS),
        .DEFAULT_CFG (DEFAULT_CFG)
    ) u_regfile (
        .clk_i     (mclk),
        .rst_i     (reset),
        .we_i      (wr_en),
        .waddr_i   (cfg_addr),
        .wdata_i   (cfg_wdata),
        .raddr_i   (cfg_addr),
        .rdata_o   (cfg_rdata),
        .bit_pad_i (pad_d),
        .bit_sel_i (bit_d),
        .bit_o     (rf_bit)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            pad_q     <= '0;
            bit_q     <= '0;
            auto_q    <= AUTO_LOAD;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_err_q  <= 1'b0;
            sresetn_q <= 1'b0;
            sclk_q    <= 1'b0;
            sdata_q   <= 1'b0;
            sload_q   <= 1'b0;
        end else begin
            sresetn_q <= 1'b1;
            auto_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_err_q  <= cfg_we && !wr_en;
            if (state_q != IDLE && state_q != DONE)
                phase_q <= phase_end ? '0 : phase_q + PW'(1);

            unique case (state_q)
                IDLE: if (go) begin
                    state_q <= SHIFT_LO;
                    busy_q  <= 1'b1;
                    phase_q <= '0;
                    pad_q   <= pad_d;
                    bit_q   <= bit_d;
                    sdata_q <= data_d;
                end
                SHIFT_LO: if (phase_end) begin
                    state_q <= SHIFT_HI;
                    sclk_q  <= 1'b1;
                end
                SHIFT_HI: if (phase_end) begin
                    sclk_q <= 1'b0;
                    if (last_bit) begin
                        state_q <= LOAD_SETUP;
                    end else begin
                        state_q <= SHIFT_LO;
                        pad_q   <= pad_d;
                        bit_q   <= bit_d;
                        sdata_q <= data_d;
                    end
                end
                LOAD_SETUP: if (phase_end) begin
                    state_q <= LOAD;
                    sload_q <= 1'b1;
                end
                LOAD: if (phase_end) begin
                    state_q <= DONE;
                    sload_q <= 1'b0;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign cfg_wr_err    = wr_err_q;
    assign serial_resetn = sresetn_q;
    assign serial_clock  = sclk_q;
    assign serial_data   = sdata_q;
    assign serial_load   = sload_q;

endmodule

// File: tb/tb_gpio_cfg_loader.sv
// Randomized bench for gpio_cfg_loader: a word-array config model and a behavioural
// shift-register chain predict every pad image the loader applies.
module tb_gpio_cfg_loader;

    localparam int NP       = 15;
    localparam int CB       = 12;
    localparam int NB       = NP * CB;
    localparam int LOAD_CYC = (2 * NB + 2) * 4 + 1;
    localparam int S_CYC    = (2 * CB + 2) * 1 + 1;

    logic mclk = 1'b0;
    logic reset = 1'b1;
    always #5 mclk = ~mclk;

    logic          cfg_we = 1'b0, start = 1'b0;
    logic [3:0]    cfg_addr = '0;
    logic [CB-1:0] cfg_wdata = '0, cfg_rdata;
    logic          busy, done, cfg_wr_err, serial_resetn, serial_clock, serial_data, serial_load;

    logic          s_we = 1'b0, s_start = 1'b0;
    logic [0:0]    s_addr = '0;
    logic [CB-1:0] s_wdata = '0, s_rdata;
    logic          s_busy, s_done, s_wr_err, s_resetn, s_clock, s_data, s_load;

    gpio_cfg_loader u_dut (
        .mclk (mclk), .reset (reset), .cfg_we (cfg_we), .cfg_addr (cfg_addr),
        .cfg_wdata (cfg_wdata), .cfg_rdata (cfg_rdata), .start (start), .busy (busy),
        .done (done), .cfg_wr_err (cfg_wr_err), .serial_resetn (serial_resetn),
        .serial_clock (serial_clock), .serial_data (serial_data), .serial_load (serial_load)
    );

    gpio_cfg_loader #(.NUM_PADS (1), .CLK_DIV (1), .AUTO_LOAD (1'b0)) u_small (
        .mclk (mclk), .reset (reset), .cfg_we (s_we), .cfg_addr (s_addr),
        .cfg_wdata (s_wdata), .cfg_rdata (s_rdata), .start (s_start), .busy (s_busy),
        .done (s_done), .cfg_wr_err (s_wr_err), .serial_resetn (s_resetn),
        .serial_clock (s_clock), .serial_data (s_data), .serial_load (s_load)
    );

    // Behavioural pad chain: first bit shifted in ends up at the far (MSB) end.
    logic [NB-1:0] chain_sr = '0, chain_img = '0;
    int            load_cnt = 0;
    always @(posedge serial_clock) chain_sr <= {chain_sr[NB-2:0], serial_data};
    always @(posedge serial_load) begin
        chain_img <= chain_sr;
        load_cnt  <= load_cnt + 1;
    end

    logic [CB-1:0] model_cfg [NP];
    int checks = 0, errors = 0;
    int busy_cnt = 0, done_cnt = 0, load_snap = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        foreach (model_cfg[i]) model_cfg[i] = 12'hC00;
    endfunction

    task automatic tick();
        @(negedge mclk);
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic cfg_write(input int addr, input logic [CB-1:0] data, input bit in_load);
        bit ok;
        ok = !in_load && (addr < NP);
        cfg_we = 1'b1; cfg_addr = 4'(addr); cfg_wdata = data;
        tick();
        cfg_we = 1'b0;
        if (ok) model_cfg[addr] = data;
        check($sformatf("wr_err@%0d", addr), cfg_wr_err, !ok);
        check($sformatf("rdata@%0d", addr), cfg_rdata, (addr < NP) ? model_cfg[addr] : 0);
    endtask

    task automatic start_load(input bit with_wr, input int addr, input logic [CB-1:0] data);
        busy_cnt = 0; done_cnt = 0; load_snap = load_cnt;
        start = 1'b1;
        if (with_wr) begin
            cfg_we = 1'b1; cfg_addr = 4'(addr); cfg_wdata = data;
        end
        tick();
        start = 1'b0; cfg_we = 1'b0;
        if (with_wr && addr < NP) model_cfg[addr] = data;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && busy !== 1'b0; i++) tick();
    endtask

    task automatic check_load(input string tag);
        check({tag, "_busy_cyc"}, busy_cnt, LOAD_CYC);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_loads"}, load_cnt - load_snap, 1);
        for (int p = 0; p < NP; p++)
            check($sformatf("%s_pad%0d", tag, p), chain_img[p*CB +: CB], model_cfg[p]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [CB-1:0] w, cap;
        logic sc [40], sd [40], sl [40], dn [40], bz [40];
        int rises, prev, lpos, lcnt, dcnt, bsum;

        model_reset();
        repeat (3) @(negedge mclk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_err", cfg_wr_err, 0);
        check("rst_resetn", serial_resetn, 0);
        check("rst_sclk", serial_clock, 0);
        check("rst_sdata", serial_data, 0);
        check("rst_sload", serial_load, 0);
        check("rst_rdata", cfg_rdata, 12'hC00);

        // Auto-load right after reset release.
        busy_cnt = 0; done_cnt = 0; load_snap = load_cnt;
        reset = 1'b0;
        tick();
        check("resetn_rel", serial_resetn, 1);
        check("auto_busy", busy, 1);
        wait_idle();
        check_load("auto");

        cfg_write(0, 12'h001, 0);
        cfg_write(14, 12'h800, 0);
        start_load(0, 0, '0);
        wait_idle();
        check_load("directed");

        cfg_write(15, 12'hABC, 0);

        for (int it = 0; it < 3; it++) begin
            for (int k = 0; k < 6; k++) cfg_write($urandom_range(0, 15), 12'($urandom), 0);
            start_load(1, $urandom_range(0, 14), 12'($urandom));
            wait_idle();
            check_load($sformatf("rand%0d", it));
        end

        // Writes and restarts while busy must be rejected / ignored.
        start_load(0, 0, '0);
        repeat (100) tick();
        cfg_write($urandom_range(0, 14), 12'($urandom), 1);
        repeat (50) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle();
        check_load("busy_ops");
        repeat (5) tick();
        check("no_restart_busy", busy, 0);
        check("no_restart_done", done_cnt, 1);

        // Reset in the middle of bit 90.
        cfg_write(0, 12'h5A5, 0);
        cfg_addr = '0;
        start_load(0, 0, '0);
        for (int i = 0; i < 2000 && busy_cnt < 90 * 8 + 3; i++) tick();
        #2 reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_resetn", serial_resetn, 0);
        check("midrst_sclk", serial_clock, 0);
        check("midrst_sdata", serial_data, 0);
        check("midrst_sload", serial_load, 0);
        check("midrst_rdata", cfg_rdata, 12'hC00);
        model_reset();
        @(negedge mclk);
        busy_cnt = 0; done_cnt = 0; load_snap = load_cnt;
        reset = 1'b0;
        tick();
        wait_idle();
        check_load("reload");

        // Single-pad, CLK_DIV=1 timing, with write and start on the same cycle.
        w = 12'($urandom);
        s_we = 1'b1; s_addr = '0; s_wdata = w; s_start = 1'b1;
        @(negedge mclk);
        s_we = 1'b0; s_start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            sc[k] = s_clock; sd[k] = s_data; sl[k] = s_load; dn[k] = s_done; bz[k] = s_busy;
            @(negedge mclk);
        end
        rises = 0; prev = -1; lpos = -1; lcnt = 0; dcnt = 0; bsum = 0; cap = '0;
        for (int k = 0; k < 40; k++) begin
            if (bz[k]) bsum++;
            if (dn[k]) dcnt++;
            if (sl[k]) begin
                lcnt++;
                lpos = k;
            end
            if (k > 0 && !sc[k-1] && sc[k]) begin
                check($sformatf("s_data_stable%0d", rises), sd[k], sd[k-1]);
                if (prev >= 0) check($sformatf("s_period%0d", rises), k - prev, 2);
                cap = {cap[CB-2:0], sd[k]};
                prev = k;
                rises++;
            end
        end
        check("s_rises", rises, CB);
        check("s_word", cap, w);
        check("s_busy_cyc", bsum, S_CYC);
        check("s_load_len", lcnt, 1);
        check("s_done_cnt", dcnt, 1);
        check("s_done_pos", (lpos >= 0 && lpos < 39) ? dn[lpos+1] : 1'b0, 1);
        check("s_rdata", s_rdata, w);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
